// File: rtl/tanh_drv.sv
// tanh_drv: request/acknowledge driver for a tanh engine.
//
// Accepts one fixed-point operand from an upstream valid/ready port, launches
// the engine with a one-cycle low pulse on wa, waits for the engine's
// result-valid (en), captures the result on the second consecutive en-high
// cycle, acknowledges with a one-cycle comp pulse and presents the result on
// a downstream valid/ready port. A sticky err flags a launch that never saw en.
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   locked               synchronous abort (returns to IDLE, drops operand)
//   in_data/in_valid/in_ready      upstream operand handshake
//   oy, wa, require      operand, start strobe (active low), request pending
//   tanh, en, comp       engine result, result-valid, completion acknowledge
//   out_data/out_valid/out_ready   downstream result handshake
//   err                  sticky timeout flag
module tanh_drv #(
  parameter int unsigned TIMEOUT = 32,
  parameter int unsigned W       = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         locked,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] oy,
  output logic         wa,
  output logic         require,
  input  logic [W-1:0] tanh,
  input  logic         en,
  output logic         comp,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         err
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_EN,
    S_SETTLE,
    S_ACK,
    S_DRAIN
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   oy_q, oy_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic           out_valid_q, out_valid_d;
  logic           err_q, err_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           accept;
  logic           timeout_hit;
  logic           capture;

  assign in_ready    = (state_q == S_IDLE) && !out_valid_q && !locked;
  assign accept      = in_ready && in_valid;
  // >= rather than == : a SETTLE bounce at the last count must still abort.
  assign timeout_hit = (state_q == S_WAIT_EN) && !en && (cnt_q >= CW'(TIMEOUT - 1));
  // en was high in WAIT_EN to get here; high again means the sign-corrected value.
  assign capture     = (state_q == S_SETTLE) && en;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; locked overrides every transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = S_LAUNCH;
      S_LAUNCH:  state_d = S_WAIT_EN;
      S_WAIT_EN: begin
        if (en)               state_d = S_SETTLE;
        else if (timeout_hit) state_d = S_IDLE;
      end
      S_SETTLE:  state_d = en ? S_ACK : S_WAIT_EN;
      S_ACK:     state_d = S_DRAIN;
      S_DRAIN:   if (!en) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (locked) state_d = S_IDLE;
  end

  // Engine-facing outputs
  always_comb begin
    wa      = (state_q != S_LAUNCH) || locked;
    comp    = (state_q == S_ACK) && !locked;
    require = (state_q == S_LAUNCH) || (state_q == S_WAIT_EN) ||
              (state_q == S_SETTLE) || (state_q == S_ACK);
  end

  // Datapath next-state
  always_comb begin
    oy_d        = oy_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    if (accept) oy_d = in_data;
    if (state_q == S_LAUNCH) cnt_d = '0;
    // Saturating so repeated SETTLE bounces cannot wrap past the abort point.
    if ((state_q == S_WAIT_EN) && (cnt_q < CW'(TIMEOUT))) cnt_d = cnt_q + CW'(1);
    if (timeout_hit && !locked) err_d = 1'b1;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (capture && !locked) begin
      out_data_d  = tanh;
      out_valid_d = 1'b1;
    end
    if (locked) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oy_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      oy_q        <= oy_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign oy        = oy_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

endmodule

// File: doc/tanh_drv.md
TANH_DRV -- requirements
Module: tanh_drv

Interface
REQ-001 Parameter TIMEOUT, default 32: maximum cycles from launch to first en before abort.
REQ-002 Parameter W, default 32: data width; all data is signed fixed point, 1 sign / 5 integer / 26 fraction bits (1.0 = 32'h0400_0000).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 locked  input  1  synchronous abort; same meaning as the tanh engine's locked input.
REQ-006 in_data  input  W  operand from upstream.
REQ-007 in_valid  input  1  in_data is valid.
REQ-008 in_ready  output  1  block accepts an operand this cycle.
REQ-009 oy  output  W  operand driven to the tanh engine.
REQ-010 wa  output  1  engine wait; high holds the engine idle, low for one cycle starts it.
REQ-011 require  output  1  high while a request is outstanding (LAUNCH..ACK).
REQ-012 tanh  input  W  engine result.
REQ-013 en  input  1  engine result-valid.
REQ-014 comp  output  1  completion acknowledge to the engine.
REQ-015 out_data  output  W  captured result.
REQ-016 out_valid  output  1  out_data is valid.
REQ-017 out_ready  input  1  downstream accepts out_data.
REQ-018 err  output  1  sticky timeout flag.

Function
REQ-019 States: IDLE, LAUNCH, WAIT_EN, SETTLE, ACK, DRAIN.
REQ-020 in_ready = 1 only in IDLE with out_valid = 0 and locked = 0.
REQ-021 IDLE: if in_valid and in_ready, oy <= in_data and go to LAUNCH.
REQ-022 LAUNCH: lasts exactly one cycle, with wa = 0; all other states drive wa = 1.
REQ-023 LAUNCH then goes to WAIT_EN, and the timeout counter clears to 0.
REQ-024 oy holds its value unchanged from LAUNCH through ACK.
REQ-025 WAIT_EN: the counter increments every cycle.
REQ-026 WAIT_EN with en = 1: go to SETTLE.
REQ-027 WAIT_EN timeout: when the counter reaches TIMEOUT-1 with en = 0, set err = 1 and go to IDLE; no result is produced.
REQ-028 SETTLE: if en = 1, out_data <= tanh, out_valid <= 1, and go to ACK.
REQ-029 SETTLE: if en = 0, return to WAIT_EN without clearing the counter.
REQ-030 Capture rule: the result is taken on the second consecutive en-high cycle, never the first, because the engine's sign correction lands one cycle after en rises.
REQ-031 ACK: comp = 1 for exactly one cycle, then go to DRAIN; comp = 0 in every other state.
REQ-032 DRAIN: stay while en = 1; go to IDLE when en = 0.
REQ-033 out_valid clears on the cycle after out_valid = 1 and out_ready = 1.
REQ-034 A new launch cannot start until out_valid = 0; no operand is ever dropped or overwritten.
REQ-035 locked = 1 in any state: go to IDLE, clear out_valid, keep err, drive wa = 1 and comp = 0; the in-flight operand is discarded.
REQ-036 locked beats every other transition in the same cycle.
REQ-037 If ACK completes and out_ready = 1 in the same cycle, capture and drain both take effect; the result is visible for one cycle.
REQ-038 No arithmetic on data; values pass through bit-exact.
REQ-039 The counter is wide enough for TIMEOUT, with no wrap before the abort.

Reset
REQ-040 rst = 0 asynchronously forces the following, independent of clk: state IDLE, wa = 1, comp = 0, require = 0, oy = 0, out_data = 0, out_valid = 0, err = 0, counter = 0.
REQ-041 When rst deasserts, the first launch can occur on the first clock edge with in_valid = 1.
REQ-042 rst asserted mid-operation abandons the operation with no comp pulse.

Verification
REQ-043 Reset: hold rst = 0 -> wa = 1, comp = 0, in_ready = 1, out_valid = 0, err = 0.
REQ-044 Normal: in_data = 32'h0200_0000 (0.5); engine model raises en, first cycle tanh = 32'h0000_1111, second cycle 32'h01D9_4A00 -> wa low exactly 1 cycle; out_data = 32'h01D9_4A00; comp = 1 for exactly 1 cycle; oy stable throughout.
REQ-045 Negative saturation: in_data = 32'hF800_0000 (-2.0); engine gives en with tanh = 32'hFC00_0000 held -> out_data = 32'hFC00_0000; DRAIN exits when en falls.
REQ-046 Back-pressure: out_ready = 0 with a second in_valid pending -> in_ready stays 0 and wa stays 1 until out_ready = 1 for one cycle, after which the second launch proceeds.
REQ-047 Timeout: engine never raises en, TIMEOUT = 32 -> err = 1 exactly 32 cycles after LAUNCH; state IDLE; no out_valid.
REQ-048 Abort: locked = 1 during WAIT_EN, and separately during ACK -> IDLE next cycle, out_valid = 0, comp = 0, wa = 1; a following operand completes normally.
